audio_capture: RTL and testbench
================================

Name: audio_capture

Overview:
- Write-side counterpart of the sound-effect playback path. Captures signed 8-bit audio samples at the 12 kHz sample strobe and writes them sequentially into an external sample BRAM (write port).
- The captured clip is later replayed by the playback block, which reads the same BRAM at the same rate.
- Supports optional threshold triggering (start on first loud sample), a programmable length and an early stop.

Parameters:
- SAMPLE_W, 8, audio sample width (signed two's complement)
- ADDR_W, 16, BRAM address width
- MAX_LEN, 65536, BRAM depth in samples (≤ 2**ADDR_W)
- THRESHOLD, 8, trigger level on |sample| (unsigned, SAMPLE_W+1 bits)

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous reset, active-low
- start_record_in  input  1  single-cycle start request
- stop_in  input  1  single-cycle early stop or abort
- trigger_en_in  input  1  sampled at start; 1 = wait for threshold before recording
- record_len_in  input  ADDR_W+1  requested sample count, sampled at start; 0 or >MAX_LEN means MAX_LEN
- sample_in  input  SAMPLE_W  signed audio sample from the front end
- sample_valid_in  input  1  sample_in is new this cycle
- signal_12khz  input  1  one-cycle sample-rate strobe
- wr_addr_out  output  ADDR_W  BRAM write address
- wr_data_out  output  SAMPLE_W  BRAM write data
- wr_en_out  output  1  BRAM write enable
- busy_out  output  1  high in ARMED or RECORD
- done_out  output  1  one-cycle pulse when a capture completes
- recorded_len_out  output  ADDR_W+1  number of samples written by the last capture
- state_out  output  2  debug: IDLE=0, ARMED=1, RECORD=2, DONE=3

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; held sample 0; count 0; latched length 0.
- Held sample:
  - Updated whenever sample_valid_in is high.
  - The value used at a strobe is sample_in if sample_valid_in is high in that cycle, otherwise the held value (bypass).
- IDLE or DONE + start_record_in:
  - Latch the length (clamped as above) and trigger_en_in.
  - Clear count and recorded_len_out.
  - Go to ARMED if trigger enabled, else RECORD.
  - No write in the start cycle, even if a strobe coincides.
- start_record_in in ARMED or RECORD is ignored.
- ARMED:
  - On a strobe, compute |s| in SAMPLE_W+1 bits, so -128 gives 128.
  - If |s| ≥ THRESHOLD: write s at address 0, count becomes 1, go to RECORD.
  - If the length is 1, go directly to DONE instead.
  - stop_in in ARMED: go to IDLE, no done_out, recorded_len_out = 0.
- RECORD:
  - On each strobe: write s at address count, then count++.
  - If count+1 equals the latched length, go to DONE.
- Write timing: wr_addr_out, wr_data_out and wr_en_out are registered and appear one cycle after the strobe. wr_en_out is high for exactly one cycle per strobe and low otherwise. wr_addr_out and wr_data_out hold their last value when wr_en_out is low.
- stop_in in RECORD:
  - Go to DONE.
  - If a strobe coincides, that write still occurs first and is counted.
- Entering DONE:
  - done_out pulses exactly once, in the cycle after the final write issue, aligned with the last wr_en_out.
  - recorded_len_out = final count.
- DONE holds until the next start. recorded_len_out persists until the next start or reset.
- Full buffer: a length of MAX_LEN writes addresses 0..MAX_LEN-1. The address never wraps.
- Reset mid-capture aborts immediately. BRAM contents are not touched; the clip is invalid.

Decomposition:
- Shared package audio_pkg:
  - state enum capture_state_t {IDLE, ARMED, RECORD, DONE}
  - SAMPLE_W, ADDR_W and the 12 kHz rate constant, shared with playback
- One small natural sub-module, audio_abs_threshold: a combinational |s| ≥ THRESHOLD compare with correct handling of -128.
- The BRAM itself stays outside this block, instantiated in the top level and shared with playback.

Test Plan:
- Untriggered, length 4: start, feed samples 5, -3, 7, 1 on four strobes -> wr_en_out pulses at addresses 0..3 with data 5, -3, 7, 1; done_out pulses once with the last write; recorded_len_out = 4.
- Triggered, THRESHOLD = 8: strobes carry 2, -7, -9, 10 -> first write is -9 at address 0, then 10 at address 1; busy_out stays high until the length is reached.
- Edge sample: triggered capture where the first strobe carries -128 -> triggers; writes 0x80 at address 0.
- Early stop: length 100, stop_in after 10 strobes, coinciding with the 10th strobe -> 10 writes (addresses 0..9); done_out pulses; recorded_len_out = 10.
- record_len_in = 0: run to completion -> exactly 65536 writes, last address 0xFFFF, no wrap; recorded_len_out = 65536.
- Abort and reset:
  - stop_in while ARMED -> IDLE, no writes, no done_out.
  - rst_n_in low mid-RECORD -> all outputs 0 immediately.
  - A new start after release records from address 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the sound-effect capture and playback paths.
package audio_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int ADDR_W         = 16;
  localparam int SAMPLE_RATE_HZ = 12000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } capture_state_t;

endpackage

// File: rtl/audio_abs_threshold.sv
// Combinational |sample| >= threshold compare on a signed sample.
module audio_abs_threshold #(
  parameter int                SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter logic [SAMPLE_W:0] THRESHOLD = (SAMPLE_W + 1)'(8)
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic                loud
);

  logic [SAMPLE_W:0] sample_ext;
  logic [SAMPLE_W:0] magnitude;

  // One extra bit so the most negative sample (-128) maps to +128 rather than overflowing.
  always_comb begin
    sample_ext = {sample[SAMPLE_W-1], sample};
    magnitude  = sample_ext[SAMPLE_W] ? (~sample_ext + 1'b1) : sample_ext;
    loud       = (magnitude >= THRESHOLD);
  end

endmodule

// File: rtl/audio_capture.sv
// Records 12 kHz signed samples into the shared sample BRAM, with optional
// threshold trigger, programmable length and early stop.
module audio_capture #(
  parameter int                SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int                ADDR_W    = audio_pkg::ADDR_W,
  parameter int                MAX_LEN   = 65536,
  parameter logic [SAMPLE_W:0] THRESHOLD = (SAMPLE_W + 1)'(8)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_record_in,
  input  logic                stop_in,
  input  logic                trigger_en_in,
  input  logic [ADDR_W:0]     record_len_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic                signal_12khz,
  output logic [ADDR_W-1:0]   wr_addr_out,
  output logic [SAMPLE_W-1:0] wr_data_out,
  output logic                wr_en_out,
  output logic                busy_out,
  output logic                done_out,
  output logic [ADDR_W:0]     recorded_len_out,
  output logic [1:0]          state_out
);

  import audio_pkg::*;

  localparam logic [ADDR_W:0] MAX_LEN_W = (ADDR_W + 1)'(MAX_LEN);

  capture_state_t      state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d, count_inc;
  logic [ADDR_W:0]     len_q, len_d, len_clamped;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic [SAMPLE_W-1:0] held_q, cur_sample;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic                loud;

  audio_abs_threshold #(
    .SAMPLE_W  (SAMPLE_W),
    .THRESHOLD (THRESHOLD)
  ) u_abs_threshold (
    .sample (cur_sample),
    .loud   (loud)
  );

  // A sample arriving in the strobe cycle bypasses the holding register.
  assign cur_sample  = sample_valid_in ? sample_in : held_q;
  assign count_inc   = count_q + 1'b1;
  assign len_clamped = ((record_len_in == '0) || (record_len_in > MAX_LEN_W)) ? MAX_LEN_W
                                                                               : record_len_in;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    rec_len_d = rec_len_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_record_in) begin
          len_d     = len_clamped;
          count_d   = '0;
          rec_len_d = '0;
          state_d   = trigger_en_in ? ARMED : RECORD;
        end
      end

      ARMED: begin
        if (stop_in) begin
          state_d = IDLE;
        end else if (signal_12khz && loud) begin
          wr_en_d = 1'b1;
          addr_d  = '0;
          data_d  = cur_sample;
          count_d = (ADDR_W + 1)'(1);
          if (len_q == (ADDR_W + 1)'(1)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            rec_len_d = (ADDR_W + 1)'(1);
          end else begin
            state_d = RECORD;
          end
        end
      end

      RECORD: begin
        // A stop that coincides with a strobe still keeps that final sample.
        if (signal_12khz) begin
          wr_en_d = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = cur_sample;
          count_d = count_inc;
          if ((count_inc == len_q) || stop_in) begin
            state_d   = DONE;
            done_d    = 1'b1;
            rec_len_d = count_inc;
          end
        end else if (stop_in) begin
          state_d   = DONE;
          done_d    = 1'b1;
          rec_len_d = count_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      len_q     <= '0;
      rec_len_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      rec_len_q <= rec_len_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      if (sample_valid_in) begin
        held_q <= sample_in;
      end
    end
  end

  assign wr_addr_out      = addr_q;
  assign wr_data_out      = data_q;
  assign wr_en_out        = wr_en_q;
  assign done_out         = done_q;
  assign recorded_len_out = rec_len_q;
  assign state_out        = state_q;
  assign busy_out         = (state_q == ARMED) || (state_q == RECORD);

endmodule

// File: tb/tb_audio_capture.sv
// Scoreboard bench for audio_capture: stimulus queues expected BRAM writes and
// done pulses, a negedge monitor pops and compares them as the DUT produces them.
module tb_audio_capture;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_record_in;
  logic        stop_in;
  logic        trigger_en_in;
  logic [16:0] record_len_in;
  logic [7:0]  sample_in;
  logic        sample_valid_in;
  logic        signal_12khz;
  logic [15:0] wr_addr_out;
  logic [7:0]  wr_data_out;
  logic        wr_en_out;
  logic        busy_out;
  logic        done_out;
  logic [16:0] recorded_len_out;
  logic [1:0]  state_out;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  typedef struct packed {
    logic [16:0] len;
    logic        with_write;
  } done_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];
  int        assert_count = 0;
  int        fail_count   = 0;

  audio_capture #(
    .SAMPLE_W  (8),
    .ADDR_W    (16),
    .MAX_LEN   (65536),
    .THRESHOLD (9'd8)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_record_in  (start_record_in),
    .stop_in          (stop_in),
    .trigger_en_in    (trigger_en_in),
    .record_len_in    (record_len_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .signal_12khz     (signal_12khz),
    .wr_addr_out      (wr_addr_out),
    .wr_data_out      (wr_data_out),
    .wr_en_out        (wr_en_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .recorded_len_out (recorded_len_out),
    .state_out        (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write and every done pulse must match the next queued expectation.
  always @(negedge clk_in) begin : monitor
    wr_exp_t   we;
    done_exp_t de;
    if (rst_n_in === 1'b1) begin
      if (wr_en_out) begin
        if (wr_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   wr_addr_out, wr_data_out);
        end else begin
          we = wr_q.pop_front();
          checkOutput("wr_addr", 32'(wr_addr_out), 32'(we.addr));
          checkOutput("wr_data", 32'(wr_data_out), 32'(we.data));
        end
      end
      if (done_out) begin
        if (done_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL unexpected_done: recorded_len 0x%0h, expected no done pulse",
                   recorded_len_out);
        end else begin
          de = done_q.pop_front();
          checkOutput("done_recorded_len", 32'(recorded_len_out), 32'(de.len));
          checkOutput("done_with_write", 32'(wr_en_out), 32'(de.with_write));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic startRec(input logic [16:0] len, input logic trig, input logic with_strobe);
    start_record_in = 1'b1;
    record_len_in   = len;
    trigger_en_in   = trig;
    if (with_strobe) begin
      signal_12khz    = 1'b1;
      sample_valid_in = 1'b1;
      sample_in       = 8'h63;
    end
    @(posedge clk_in);
    #1;
    start_record_in = 1'b0;
    signal_12khz    = 1'b0;
    sample_valid_in = 1'b0;
  endtask

  // One cycle of front-end activity plus the write/done it should cause.
  task automatic applyStimulus(input logic [7:0] s, input logic valid, input logic strobe,
                               input logic stop, input logic exp_write, input logic [15:0] exp_addr,
                               input logic [7:0] exp_data, input logic exp_done,
                               input logic [16:0] exp_len);
    sample_in       = s;
    sample_valid_in = valid;
    signal_12khz    = strobe;
    stop_in         = stop;
    if (exp_write) wr_q.push_back('{addr: exp_addr, data: exp_data});
    if (exp_done)  done_q.push_back('{len: exp_len, with_write: exp_write});
    @(posedge clk_in);
    #1;
    sample_valid_in = 1'b0;
    signal_12khz    = 1'b0;
    stop_in         = 1'b0;
  endtask

  initial begin
    start_record_in = 1'b0;
    stop_in         = 1'b0;
    trigger_en_in   = 1'b0;
    record_len_in   = '0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    signal_12khz    = 1'b0;
    rst_n_in        = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset_wr_en", 32'(wr_en_out), 0);
    checkOutput("reset_wr_addr", 32'(wr_addr_out), 0);
    checkOutput("reset_done", 32'(done_out), 0);
    checkOutput("reset_busy", 32'(busy_out), 0);
    checkOutput("reset_state", 32'(state_out), 0);
    checkOutput("reset_rec_len", 32'(recorded_len_out), 0);
    rst_n_in = 1'b1;
    idle(1);

    $display("[TB] untriggered capture, length 4");
    startRec(17'd4, 1'b0, 1'b1);
    checkOutput("t1_state_record", 32'(state_out), 2);
    checkOutput("t1_busy", 32'(busy_out), 1);
    applyStimulus(8'h05, 1, 1, 0, 1, 16'd0, 8'h05, 0, 0);
    idle(2);
    applyStimulus(8'hFD, 1, 1, 0, 1, 16'd1, 8'hFD, 0, 0);
    idle(1);
    applyStimulus(8'h07, 1, 1, 0, 1, 16'd2, 8'h07, 0, 0);
    applyStimulus(8'h01, 1, 1, 0, 1, 16'd3, 8'h01, 1, 17'd4);
    idle(2);
    checkOutput("t1_rec_len", 32'(recorded_len_out), 4);
    checkOutput("t1_state_done", 32'(state_out), 3);
    checkOutput("t1_busy_low", 32'(busy_out), 0);

    $display("[TB] triggered capture, threshold 8");
    startRec(17'd2, 1'b1, 1'b0);
    checkOutput("t2_state_armed", 32'(state_out), 1);
    checkOutput("t2_busy_armed", 32'(busy_out), 1);
    applyStimulus(8'h02, 1, 1, 0, 0, 16'd0, 8'h00, 0, 0);
    applyStimulus(8'hF9, 1, 1, 0, 0, 16'd0, 8'h00, 0, 0);
    applyStimulus(8'hF7, 1, 1, 0, 1, 16'd0, 8'hF7, 0, 0);
    checkOutput("t2_state_record", 32'(state_out), 2);
    checkOutput("t2_busy_record", 32'(busy_out), 1);
    applyStimulus(8'h0A, 1, 1, 0, 1, 16'd1, 8'h0A, 1, 17'd2);
    idle(2);
    checkOutput("t2_busy_low", 32'(busy_out), 0);
    checkOutput("t2_rec_len", 32'(recorded_len_out), 2);

    $display("[TB] -128 trigger, held-sample bypass, stop without strobe");
    startRec(17'd3, 1'b1, 1'b0);
    applyStimulus(8'h80, 1, 1, 0, 1, 16'd0, 8'h80, 0, 0);
    applyStimulus(8'h21, 1, 0, 0, 0, 16'd0, 8'h00, 0, 0);
    applyStimulus(8'h63, 0, 1, 0, 1, 16'd1, 8'h21, 0, 0);
    applyStimulus(8'h00, 0, 0, 1, 0, 16'd0, 8'h00, 1, 17'd2);
    idle(2);
    checkOutput("t3_rec_len", 32'(recorded_len_out), 2);
    checkOutput("t3_state_done", 32'(state_out), 3);

    $display("[TB] early stop on 10th strobe, start ignored while recording");
    startRec(17'd100, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) startRec(17'd2, 1'b0, 1'b0);
      applyStimulus(8'(i + 16), 1, 1, (i == 9), 1, 16'(i), 8'(i + 16), (i == 9), 17'd10);
    end
    idle(2);
    checkOutput("t4_rec_len", 32'(recorded_len_out), 10);
    checkOutput("t4_state_done", 32'(state_out), 3);

    $display("[TB] stop while armed");
    startRec(17'd5, 1'b1, 1'b0);
    applyStimulus(8'h03, 1, 1, 0, 0, 16'd0, 8'h00, 0, 0);
    applyStimulus(8'h00, 0, 0, 1, 0, 16'd0, 8'h00, 0, 0);
    idle(2);
    checkOutput("t5_state_idle", 32'(state_out), 0);
    checkOutput("t5_busy", 32'(busy_out), 0);
    checkOutput("t5_rec_len", 32'(recorded_len_out), 0);

    $display("[TB] reset mid-record, then fresh capture");
    startRec(17'd10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'(8'h40 + i), 1, 1, 0, 1, 16'(i), 8'(8'h40 + i), 0, 0);
    end
    idle(1);
    #1;
    rst_n_in = 1'b0;
    #1;
    checkOutput("t6_rst_wr_en", 32'(wr_en_out), 0);
    checkOutput("t6_rst_wr_addr", 32'(wr_addr_out), 0);
    checkOutput("t6_rst_wr_data", 32'(wr_data_out), 0);
    checkOutput("t6_rst_busy", 32'(busy_out), 0);
    checkOutput("t6_rst_state", 32'(state_out), 0);
    checkOutput("t6_rst_done", 32'(done_out), 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    idle(1);
    startRec(17'd2, 1'b0, 1'b0);
    applyStimulus(8'h11, 1, 1, 0, 1, 16'd0, 8'h11, 0, 0);
    applyStimulus(8'h22, 1, 1, 0, 1, 16'd1, 8'h22, 1, 17'd2);
    idle(2);
    checkOutput("t6_rec_len", 32'(recorded_len_out), 2);

    $display("[TB] length 0 selects the full 65536-sample buffer");
    startRec(17'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      sample_in       = 8'(i * 7);
      sample_valid_in = 1'b1;
      signal_12khz    = 1'b1;
      wr_q.push_back('{addr: 16'(i), data: 8'(i * 7)});
      if (i == 65535) done_q.push_back('{len: 17'h10000, with_write: 1'b1});
      @(posedge clk_in);
      #1;
    end
    sample_valid_in = 1'b0;
    signal_12khz    = 1'b0;
    idle(3);
    checkOutput("t7_rec_len", 32'(recorded_len_out), 32'h10000);
    checkOutput("t7_last_addr", 32'(wr_addr_out), 32'hFFFF);
    checkOutput("t7_state_done", 32'(state_out), 3);

    checkOutput("pending_writes", 32'(wr_q.size()), 0);
    checkOutput("pending_dones", 32'(done_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
